note_scheduler: RTL



---
 rtl/note_sched_pkg.sv | 35 +++
 rtl/note_slot.sv | 58 +++++
 rtl/note_scheduler.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/note_sched_pkg.sv
// ============================================================================
// Module      : note_sched_pkg
// Description : Shared types and default geometry for the note scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package note_sched_pkg;

    localparam int c_num_lanes = 5;
    localparam int c_y_w       = 10;
    localparam int c_y_top     = 35;
    localparam int c_y_bottom  = 500;
    localparam int c_speed     = 5;
    localparam int c_note_h    = 35;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PLAY  = 3'd1,
        ST_FETCH = 3'd2,
        ST_SPAWN = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Slot mask width is fixed here; the top-level NUM_LANES must match it.
    typedef struct packed {
        logic                   valid;
        logic [c_num_lanes-1:0] mask;
        logic [c_y_w-1:0]       y;
    } slot_t;

endpackage

`default_nettype wire

// File: rtl/note_slot.sv
// ============================================================================
// Module      : note_slot
// Description : One falling-note slot: load, advance/retire, row coverage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module note_slot
    import note_sched_pkg::*;
#(
    parameter int Y_BOTTOM = c_y_bottom,
    parameter int SPEED    = c_speed,
    parameter int NOTE_H   = c_note_h
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_advance,
    input  logic                   i_load,
    input  logic [c_num_lanes-1:0] i_load_mask,
    input  logic [c_y_w-1:0]       i_load_y,
    input  logic [c_y_w-1:0]       i_row,
    output logic                   o_valid,
    output logic [c_num_lanes-1:0] o_hit
);

    slot_t       r_slot;
    logic [10:0] w_sum;
    logic        w_cover;

    assign w_sum = {1'b0, r_slot.y} + 11'(SPEED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot <= '0;
        end else if (i_load) begin
            r_slot.valid <= 1'b1;
            r_slot.mask  <= i_load_mask;
            r_slot.y     <= i_load_y;
        end else if (i_advance && r_slot.valid) begin
            if (w_sum >= 11'(Y_BOTTOM)) begin
                r_slot.valid <= 1'b0;
            end else begin
                r_slot.y <= w_sum[c_y_w-1:0];
            end
        end
    end

    // (y - NOTE_H) < row rearranged as y < row + NOTE_H so nothing underflows.
    assign w_cover = r_slot.valid
                   && ({1'b0, i_row} <= {1'b0, r_slot.y})
                   && ({1'b0, r_slot.y} < ({1'b0, i_row} + 11'(NOTE_H)));

    assign o_valid = r_slot.valid;
    assign o_hit   = w_cover ? r_slot.mask : '0;

endmodule

`default_nettype wire

// File: rtl/note_scheduler.sv
// ============================================================================
// Module      : note_scheduler
// Description : Chart sequencer and slot table for the falling-note display.
//               Define NOTE_SCHED_LOOP_EN to loop the chart forever.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module note_scheduler
    import note_sched_pkg::*;
#(
    parameter int NUM_LANES       = c_num_lanes,
    parameter int NUM_SLOTS       = 8,
    parameter int CHART_LEN       = 64,
    parameter int ADDR_W          = 6,
    parameter int FRAMES_PER_STEP = 8,
    parameter int Y_TOP           = c_y_top,
    parameter int Y_BOTTOM        = c_y_bottom,
    parameter int SPEED           = c_speed,
    parameter int NOTE_H          = c_note_h
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           frame_tick,
    output logic [ADDR_W-1:0]              chart_addr,
    input  logic [NUM_LANES-1:0]           chart_data,
    input  logic [9:0]                     row,
    output logic [NUM_LANES-1:0]           lane_hit,
    output logic                           busy,
    output logic                           done,
    output logic                           overflow,
    output logic [$clog2(NUM_SLOTS+1)-1:0] live_count
);

    localparam int CNT_W  = $clog2(NUM_SLOTS + 1);
    localparam int STEP_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    state_t                     r_state;
    state_t                     w_next;
    logic [ADDR_W-1:0]          r_chart_addr;
    logic [STEP_W-1:0]          r_step_cnt;
    logic                       r_overflow;
    logic                       w_busy;
    logic                       w_advance;
    logic                       w_spawn;
    logic                       w_last_row;
    logic                       w_free_found;
    logic [NUM_SLOTS-1:0]       w_valid;
    logic [NUM_SLOTS-1:0]       w_load;
    logic [NUM_LANES-1:0]       w_hit [NUM_SLOTS];
    logic [NUM_LANES-1:0]       w_hit_or;
    logic [CNT_W-1:0]           w_live;

    assign w_last_row = (r_chart_addr == ADDR_W'(CHART_LEN - 1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_next = ST_PLAY;
            ST_PLAY:  if (frame_tick && (r_step_cnt == '0)) w_next = ST_FETCH;
            ST_FETCH: w_next = ST_SPAWN;
            ST_SPAWN: begin
`ifdef NOTE_SCHED_LOOP_EN
                w_next = ST_PLAY;
`else
                w_next = w_last_row ? ST_DRAIN : ST_PLAY;
`endif
            end
            ST_DRAIN: if (w_live == '0) w_next = ST_DONE;
            ST_DONE:  if (start) w_next = ST_PLAY;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        w_busy    = (r_state != ST_IDLE) && (r_state != ST_DONE);
        done      = (r_state == ST_DONE);
        w_advance = w_busy && frame_tick;
        w_spawn   = (r_state == ST_SPAWN) && (chart_data != '0);
    end

    // Chart position, step divider and sticky overflow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_chart_addr <= '0;
            r_step_cnt   <= '0;
            r_overflow   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_chart_addr <= '0;
                        r_step_cnt   <= '0;
                        r_overflow   <= 1'b0;
                    end
                end
                ST_PLAY: begin
                    if (frame_tick) begin
                        r_step_cnt <= (r_step_cnt == STEP_W'(FRAMES_PER_STEP - 1))
                                    ? '0 : r_step_cnt + 1'b1;
                    end
                end
                ST_SPAWN: begin
                    if (w_spawn && !w_free_found) begin
                        r_overflow <= 1'b1;
                    end
                    if (!w_last_row) begin
                        r_chart_addr <= r_chart_addr + 1'b1;
                    end else begin
`ifdef NOTE_SCHED_LOOP_EN
                        r_chart_addr <= '0;
`else
                        r_chart_addr <= r_chart_addr;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    // Lowest-index free slot takes the new row; also counts live slots
    always_comb begin
        w_free_found = 1'b0;
        w_load       = '0;
        w_live       = '0;
        w_hit_or     = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!w_valid[i] && !w_free_found) begin
                w_load[i]    = w_spawn;
                w_free_found = 1'b1;
            end
            w_live   = w_live + CNT_W'(w_valid[i]);
            w_hit_or = w_hit_or | w_hit[i];
        end
    end

    generate
        for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
            note_slot #(
                .Y_BOTTOM (Y_BOTTOM),
                .SPEED    (SPEED),
                .NOTE_H   (NOTE_H)
            ) u_slot (
                .clk         (clk),
                .rst         (reset),
                .i_advance   (w_advance),
                .i_load      (w_load[g]),
                .i_load_mask (chart_data),
                .i_load_y    (c_y_w'(Y_TOP)),
                .i_row       (row),
                .o_valid     (w_valid[g]),
                .o_hit       (w_hit[g])
            );
        end
    endgenerate

    assign chart_addr = r_chart_addr;
    assign overflow   = r_overflow;
    assign busy       = w_busy;
    assign live_count = w_live;
    assign lane_hit   = w_hit_or;

endmodule

`default_nettype wire
